ff_bist: RTL and testbench
==========================

# ff_bist

Built-in self-test driver and checker for a registered flip-flop stage of width SIZE. It owns the bench side of the flop's interface: it drives `data_i` and `reset` into the flop and samples `data_o`. Stimulus comes from an LFSR, and each sample is compared against a delayed copy of the stimulus. The block reports pass/fail, an error count and the first failing index. It sits beside the flop under test, so flop regressions can run on hardware without a simulator.

## Interface
Parameters:
- SIZE, 1 — flop data width; legal range 1..32.
- NUM_VECTORS, 256 — stimulus vectors per run; legal range 1..65534.
- RESET_CYCLES, 2 — cycles the flop is held in reset before stimulus; ≥1.
- LATENCY, 1 — flop latency in cycles, data_i to data_o; ≥1.
- SEED, 32'hACE1_0001 — LFSR load value; must be nonzero.

Ports:
- clk  in  1  — single clock for the block and the flop under test.
- reset  in  1  — asynchronous, active-high block reset.
- start  in  1  — one-cycle request to begin a run.
- dut_data_i  out  SIZE  — stimulus to the flop's data_i.
- dut_reset  out  1  — drives the flop's reset.
- dut_data_o  in  SIZE  — flop output under test.
- busy  out  1  — run in progress.
- done  out  1  — run complete; holds until the next accepted start.
- pass  out  1  — equals done && err_count==0.
- err_count  out  16  — mismatch count; saturates at 16'hFFFF.
- first_err_idx  out  16  — compare index of the first mismatch; 16'hFFFF if none.

## Operation
- FSM states: IDLE, DUT_RST, RUN, DRAIN, DONE.
- IDLE → DUT_RST on start. DUT_RST lasts RESET_CYCLES cycles, then → RUN.
- RUN lasts NUM_VECTORS cycles, then → DRAIN. DRAIN lasts LATENCY cycles, then → DONE.
- DONE → DUT_RST on start; this restarts the run and clears the results.
- start is ignored in DUT_RST, RUN and DRAIN.
- dut_reset is 1 in IDLE, DUT_RST and DONE, and 0 in RUN and DRAIN.
- dut_data_i is 0 outside RUN. In RUN it equals the low SIZE bits of the LFSR.
- LFSR: 32-bit Galois, polynomial x^32+x^22+x^2+x+1.
  - Loaded with SEED on entry to DUT_RST.
  - Advances once per RUN cycle, after the current value is driven.
- Expected pipeline: LATENCY stages of SIZE bits.
  - Cleared to 0 in DUT_RST, so the flop's reset value of 0 is checked first.
  - Shifts in dut_data_i on every RUN and DRAIN cycle.
- Compare: on every RUN and DRAIN cycle, dut_data_o is compared against the pipeline tail.
  - Compare index k runs 0 .. NUM_VECTORS+LATENCY-1.
  - Indices 0..LATENCY-1 check the reset value.
- On a mismatch, err_count increments, saturating at 16'hFFFF. If no earlier error was seen, first_err_idx is set to k.
- Entry to DUT_RST clears err_count to 0, sets first_err_idx to 16'hFFFF and clears done.

## Timing
- Reset values: state IDLE, dut_reset=1, dut_data_i=0, busy=0, done=0, pass=0, err_count=0, first_err_idx=16'hFFFF.
- An asserted reset mid-run returns the FSM to IDLE immediately (asynchronously). Results are discarded.
- All outputs are registered, with no combinational input→output paths.
- start is sampled at a posedge while in IDLE or DONE. busy rises in the next cycle.
- done and pass rise exactly RESET_CYCLES+NUM_VECTORS+LATENCY cycles after the sampling edge. busy falls in the same cycle.
- A compare of index k uses dut_data_o sampled at the same posedge that ends cycle k.
- The final error count is visible in the first DONE cycle.
- Saturation: once err_count is 16'hFFFF, further mismatches leave it at 16'hFFFF.

## Structure
- Package ff_bist_pkg holds:
  - the state enum;
  - the LFSR polynomial constant (32'h8020_0003, Galois form);
  - the default seed;
  - the 16'hFFFF constant, used both as the "no error" marker and as the saturation limit.
- Sub-module ff_bist_lfsr: 32-bit Galois LFSR with ports load, seed, advance, value.

## Test plan
- Correct flop, SIZE=8, NUM_VECTORS=16, LATENCY=1, RESET_CYCLES=2: pulse start → done after 19 cycles, pass=1, err_count=0, first_err_idx=16'hFFFF.
- Flop with bit 3 stuck at 1: run as above → pass=0, err_count>0, first_err_idx=0 (reset-value check fails at k=0).
- Flop with a 2-cycle delay while LATENCY=1: → first_err_idx=1; with LATENCY=2 the same flop passes.
- Assert reset at cycle 10 of RUN → all outputs return to their reset values within the cycle. A new start then completes normally with pass=1.
- Pulse start during RUN, then again in DONE → the first pulse is ignored. The second restarts the run: done=0 and err_count=0 in the next cycle, and dut_data_i repeats the same vector sequence from SEED.
- Flop output inverted, NUM_VECTORS=65534 → err_count=16'hFFFF (saturated), no wrap, first_err_idx=0.

Source files
------------

// File: rtl/ff_bist_pkg.sv
// Shared types and constants for the flip-flop BIST block.
// The LFSR step function lives here so the LFSR and its consumers agree on one definition.
package ff_bist_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StDutRst,
    StRun,
    StDrain,
    StDone
  } state_e;

  // Galois taps for x^32 + x^22 + x^2 + x + 1, right-shifting form.
  localparam logic [31:0] LfsrPoly    = 32'h8020_0003;
  localparam logic [31:0] DefaultSeed = 32'hACE1_0001;

  // Doubles as the "no error seen" index marker and the error-count ceiling.
  localparam logic [15:0] Max16 = 16'hFFFF;

  function automatic logic [31:0] lfsr_step(logic [31:0] v);
    return (v >> 1) ^ (v[0] ? LfsrPoly : 32'h0);
  endfunction

endpackage

// File: rtl/ff_bist_lfsr.sv
// 32-bit Galois LFSR: load has priority over advance, value is the current register.
module ff_bist_lfsr
  import ff_bist_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] seed,
  input  logic        advance,
  output logic [31:0] value
);

  logic [31:0] value_q, value_d;

  always_comb begin
    value_d = value_q;
    if (load) begin
      value_d = seed;
    end else if (advance) begin
      value_d = lfsr_step(value_q);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value_q <= DefaultSeed;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/ff_bist.sv
// BIST driver/checker for a registered flop stage: drives LFSR stimulus, compares the flop
// output against a LATENCY-deep expected pipeline, and reports pass, error count and first index.
module ff_bist
  import ff_bist_pkg::*;
#(
  parameter int unsigned SIZE         = 1,
  parameter int unsigned NUM_VECTORS  = 256,
  parameter int unsigned RESET_CYCLES = 2,
  parameter int unsigned LATENCY      = 1,
  parameter logic [31:0] SEED         = DefaultSeed
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  output logic [SIZE-1:0] dut_data_i,
  output logic            dut_reset,
  input  logic [SIZE-1:0] dut_data_o,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [15:0]     err_count,
  output logic [15:0]     first_err_idx
);

  state_e state_q, state_d;

  logic [31:0]     cnt_q, cnt_d;
  logic [15:0]     idx_q, idx_d;
  logic [15:0]     err_q, err_d;
  logic [15:0]     first_q, first_d;
  logic [SIZE-1:0] stim_q, stim_d;
  logic [SIZE-1:0] pipe_q [LATENCY];
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;
  logic            dut_rst_q, dut_rst_d;

  logic            start_ok;
  logic            comparing;
  logic            mismatch;
  logic            lfsr_advance;
  logic [31:0]     lfsr_value;
  logic [31:0]     lfsr_next;

  assign start_ok     = start && (state_q == StIdle || state_q == StDone);
  assign comparing    = (state_q == StRun) || (state_q == StDrain);
  assign mismatch     = comparing && (dut_data_o != pipe_q[LATENCY-1]);
  assign lfsr_advance = (state_q == StRun);

  ff_bist_lfsr u_lfsr (
    .clk     (clk),
    .reset   (reset),
    .load    (start_ok),
    .seed    (SEED),
    .advance (lfsr_advance),
    .value   (lfsr_value)
  );

  // State register and phase counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) state_d = StDutRst;
      end
      StDutRst: begin
        if (cnt_q == 32'(RESET_CYCLES - 1)) state_d = StRun;
      end
      StRun: begin
        if (cnt_q == 32'(NUM_VECTORS - 1)) state_d = StDrain;
      end
      StDrain: begin
        if (cnt_q == 32'(LATENCY - 1)) state_d = StDone;
      end
      default: state_d = StIdle;
    endcase
    cnt_d = (state_d != state_q) ? '0 : cnt_q + 32'd1;
  end

  // Result tracking: cleared on an accepted start, updated on every compare cycle.
  always_comb begin
    err_d   = err_q;
    first_d = first_q;
    idx_d   = idx_q;
    if (start_ok) begin
      err_d   = '0;
      first_d = Max16;
      idx_d   = '0;
    end else if (comparing) begin
      idx_d = idx_q + 16'd1;
      if (mismatch) begin
        if (err_q != Max16) err_d = err_q + 16'd1;
        // err_q rather than first_q: a genuine index can itself be 16'hFFFF.
        if (err_q == '0) first_d = idx_q;
      end
    end
  end

  // Output logic, computed from the next state so every output leaves a register.
  always_comb begin
    busy_d    = state_d inside {StDutRst, StRun, StDrain};
    done_d    = (state_d == StDone);
    pass_d    = done_d && (err_d == '0);
    dut_rst_d = !(state_d inside {StRun, StDrain});
    lfsr_next = lfsr_advance ? lfsr_step(lfsr_value) : lfsr_value;
    stim_d    = (state_d == StRun) ? lfsr_next[SIZE-1:0] : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q     <= '0;
      err_q     <= '0;
      first_q   <= Max16;
      stim_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      dut_rst_q <= 1'b1;
    end else begin
      idx_q     <= idx_d;
      err_q     <= err_d;
      first_q   <= first_d;
      stim_q    <= stim_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      dut_rst_q <= dut_rst_d;
    end
  end

  // Expected pipeline: zeros first so the flop's reset value is checked before the stimulus.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(LATENCY); i++) pipe_q[i] <= '0;
    end else if (state_q == StDutRst) begin
      for (int i = 0; i < int'(LATENCY); i++) pipe_q[i] <= '0;
    end else if (comparing) begin
      pipe_q[0] <= stim_q;
      for (int i = 1; i < int'(LATENCY); i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign dut_data_i    = stim_q;
  assign dut_reset     = dut_rst_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign err_count     = err_q;
  assign first_err_idx = first_q;

endmodule

// File: tb/tb_ff_bist.sv
// Bench for ff_bist: three BIST instances each driving a behavioural flop (with selectable
// faults), checked against a reference model built from the LFSR/compare rules.
module tb_ff_bist;

  localparam int RA = 2, NA = 16, LA = 1;
  localparam int RB = 2, NB = 16, LB = 2;
  localparam int RC = 1, NC = 65534, LC = 2;
  localparam logic [31:0] SEED_TB = 32'hACE1_0001;
  // Taps from the polynomial exponents 32, 22, 2, 1 (exponent e -> bit e-1).
  localparam logic [31:0] TAPS = (32'd1 << 31) | (32'd1 << 21) | (32'd1 << 1) | (32'd1 << 0);

  logic clk, reset;

  logic       start_a, rst_a, busy_a, done_a, pass_a;
  logic [7:0] dat_i_a, dat_o_a;
  logic [15:0] err_a, first_a;

  logic       start_b, rst_b, busy_b, done_b, pass_b;
  logic [7:0] dat_i_b, dat_o_b;
  logic [15:0] err_b, first_b;

  logic       start_c, rst_c, busy_c, done_c, pass_c;
  logic [3:0] dat_i_c, dat_o_c;
  logic [15:0] err_c, first_c;

  int mode_a, stuck_a;
  int checks, errors;

  logic [31:0] exp_stim[$];
  int exp_err, exp_first;

  ff_bist #(.SIZE(8), .NUM_VECTORS(NA), .RESET_CYCLES(RA), .LATENCY(LA)) u_dut_a (
    .clk(clk), .reset(reset), .start(start_a), .dut_data_i(dat_i_a), .dut_reset(rst_a),
    .dut_data_o(dat_o_a), .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a),
    .first_err_idx(first_a)
  );

  ff_bist #(.SIZE(8), .NUM_VECTORS(NB), .RESET_CYCLES(RB), .LATENCY(LB)) u_dut_b (
    .clk(clk), .reset(reset), .start(start_b), .dut_data_i(dat_i_b), .dut_reset(rst_b),
    .dut_data_o(dat_o_b), .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b),
    .first_err_idx(first_b)
  );

  ff_bist #(.SIZE(4), .NUM_VECTORS(NC), .RESET_CYCLES(RC), .LATENCY(LC)) u_dut_c (
    .clk(clk), .reset(reset), .start(start_c), .dut_data_i(dat_i_c), .dut_reset(rst_c),
    .dut_data_o(dat_o_c), .busy(busy_c), .done(done_c), .pass(pass_c), .err_count(err_c),
    .first_err_idx(first_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Flops under test. A: mode 0 good, 1 stuck bit, 2 two-cycle delay, 3 inverted.
  logic [7:0] fa_s1, fa_s2, fb_s1, fb_s2;
  logic [3:0] fc_s1, fc_s2;

  always_ff @(posedge clk or posedge rst_a)
    if (rst_a) begin fa_s1 <= '0; fa_s2 <= '0; end
    else begin fa_s1 <= dat_i_a; fa_s2 <= fa_s1; end

  always_comb begin
    case (mode_a)
      0:       dat_o_a = fa_s1;
      1:       dat_o_a = fa_s1 | (8'd1 << stuck_a);
      2:       dat_o_a = fa_s2;
      default: dat_o_a = ~fa_s1;
    endcase
  end

  always_ff @(posedge clk or posedge rst_b)
    if (rst_b) begin fb_s1 <= '0; fb_s2 <= '0; end
    else begin fb_s1 <= dat_i_b; fb_s2 <= fb_s1; end
  assign dat_o_b = fb_s2;

  always_ff @(posedge clk or posedge rst_c)
    if (rst_c) begin fc_s1 <= '0; fc_s2 <= '0; end
    else begin fc_s1 <= dat_i_c; fc_s2 <= fc_s1; end
  assign dat_o_c = ~fc_s2;

  function automatic logic [31:0] lfsr_adv(input logic [31:0] v);
    return v[0] ? ((v >> 1) ^ TAPS) : (v >> 1);
  endfunction

  function automatic logic [31:0] stim_at(input int j);
    return (j >= 0 && j < exp_stim.size()) ? exp_stim[j] : 32'h0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: stimulus list, then per-index expected vs faulty-flop output.
  // mode 0 good, 1 stuck bit, 2 delay 2, 3 inverted, 4 inverted with delay 2.
  task automatic build_model(input int n, input int size, input int lat, input int mode,
                             input int bit_n);
    logic [31:0] v, mask, r, o;
    int d, cnt;
    mask = (size >= 32) ? 32'hFFFF_FFFF : ((32'd1 << size) - 32'd1);
    v = SEED_TB;
    exp_stim.delete();
    for (int j = 0; j < n; j++) begin
      exp_stim.push_back(v & mask);
      v = lfsr_adv(v);
    end
    d = (mode == 2 || mode == 4) ? 2 : 1;
    cnt = 0;
    exp_first = 32'hFFFF;
    for (int k = 0; k < n + lat; k++) begin
      r = (k < lat) ? 32'h0 : stim_at(k - lat);
      o = (k < d) ? 32'h0 : stim_at(k - d);
      if (mode == 1) o = o | (32'd1 << bit_n);
      if (mode >= 3) o = ~o & mask;
      if (o != r) begin
        if (cnt == 0) exp_first = k;
        cnt++;
      end
    end
    exp_err = (cnt > 65535) ? 65535 : cnt;
  endtask

  // Call at a negedge. Optionally pulses start again during RUN (must be ignored).
  task automatic run_a(input int mode, input int bit_n, input bit pulse_mid, input string tag);
    int done_at, bad;
    logic exp_rst;
    logic [7:0] exp_d;
    mode_a = mode;
    stuck_a = bit_n;
    build_model(NA, 8, LA, mode, bit_n);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    check({tag, "/busy_rise"}, {31'b0, busy_a}, 1);
    check({tag, "/done_clr"}, {31'b0, done_a}, 0);
    check({tag, "/err_clr"}, {16'b0, err_a}, 0);
    check({tag, "/first_clr"}, {16'b0, first_a}, 32'hFFFF);
    done_at = -1;
    bad = 0;
    for (int c = 0; c < RA + NA + LA + 20; c++) begin
      if (done_a) begin
        done_at = c;
        break;
      end
      exp_rst = !(c >= RA && c < RA + NA + LA);
      exp_d = (c >= RA && c < RA + NA) ? exp_stim[c - RA][7:0] : 8'h0;
      if (dat_i_a !== exp_d || rst_a !== exp_rst) bad++;
      start_a = (pulse_mid && c == RA + 3);
      @(negedge clk);
    end
    start_a = 1'b0;
    check({tag, "/stream"}, bad, 0);
    check({tag, "/done_at"}, done_at, RA + NA + LA);
    check({tag, "/busy_fall"}, {31'b0, busy_a}, 0);
    check({tag, "/pass"}, {31'b0, pass_a}, {31'b0, exp_err == 0});
    check({tag, "/err"}, {16'b0, err_a}, exp_err);
    check({tag, "/first"}, {16'b0, first_a}, exp_first);
  endtask

  initial begin
    int done_at;
    checks = 0;
    errors = 0;
    reset = 1'b1;
    start_a = 0; start_b = 0; start_c = 0;
    mode_a = 0; stuck_a = 0;
    repeat (2) @(negedge clk);
    check("rst/dut_reset", {31'b0, rst_a}, 1);
    check("rst/data_i", {24'b0, dat_i_a}, 0);
    check("rst/busy", {31'b0, busy_a}, 0);
    check("rst/done", {31'b0, done_a}, 0);
    check("rst/pass", {31'b0, pass_a}, 0);
    check("rst/err", {16'b0, err_a}, 0);
    check("rst/first", {16'b0, first_a}, 32'hFFFF);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("idle/busy", {31'b0, busy_a}, 0);

    run_a(0, 0, 1'b0, "good");
    run_a(1, 3, 1'b0, "stuck3");
    check("stuck3/first0", {16'b0, first_a}, 0);
    check("stuck3/err_nz", {31'b0, err_a != 16'h0}, 1);
    run_a(2, 0, 1'b0, "delay2");
    check("delay2/first1", {16'b0, first_a}, 1);
    // Restart straight from a failing DONE, with a stray start during RUN.
    run_a(0, 0, 1'b1, "restart");

    // Asynchronous reset in RUN cycle 10 with an inverting flop.
    mode_a = 3;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (RA + 10) @(negedge clk);
    check("midrst/err_before", {31'b0, err_a != 16'h0}, 1);
    reset = 1'b1;
    #1;
    check("midrst/busy", {31'b0, busy_a}, 0);
    check("midrst/done", {31'b0, done_a}, 0);
    check("midrst/pass", {31'b0, pass_a}, 0);
    check("midrst/dut_reset", {31'b0, rst_a}, 1);
    check("midrst/data_i", {24'b0, dat_i_a}, 0);
    check("midrst/err", {16'b0, err_a}, 0);
    check("midrst/first", {16'b0, first_a}, 32'hFFFF);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    run_a(0, 0, 1'b0, "after_rst");

    for (int i = 0; i < 6; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_a(int'($urandom_range(0, 3)), int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
            $sformatf("rand%0d", i));
    end

    // Two-cycle flop with matching LATENCY passes.
    build_model(NB, 8, LB, 2, 0);
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    done_at = -1;
    for (int c = 0; c < RB + NB + LB + 20; c++) begin
      if (done_b) begin done_at = c; break; end
      @(negedge clk);
    end
    check("lat2/done_at", done_at, RB + NB + LB);
    check("lat2/pass", {31'b0, pass_b}, 1);
    check("lat2/err", {16'b0, err_b}, exp_err);
    check("lat2/first", {16'b0, first_b}, exp_first);

    // Every compare fails: 65536 mismatches must stop at the ceiling, not wrap.
    build_model(NC, 4, LC, 4, 0);
    start_c = 1'b1;
    @(negedge clk);
    start_c = 1'b0;
    done_at = -1;
    for (int c = 0; c < RC + NC + LC + 20; c++) begin
      if (done_c) begin done_at = c; break; end
      @(negedge clk);
    end
    check("sat/done_at", done_at, RC + NC + LC);
    check("sat/err", {16'b0, err_c}, exp_err);
    check("sat/err_max", {16'b0, err_c}, 32'hFFFF);
    check("sat/first", {16'b0, first_c}, exp_first);
    check("sat/pass", {31'b0, pass_c}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
